program_counter_saltos: RTL and testbench



---
 rtl/pc_pkg.sv | 20 ++
 rtl/pila_retorno.sv | 54 +++++
 rtl/program_counter_saltos.sv | 140 ++++++++++++++
 tb/tb_program_counter_saltos.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the filter-sequencer program counter: opcode
// values, opcode field position and the fetch FSM state encoding.
package pc_pkg;

   localparam int INSTR_W = 32;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;

   localparam logic [3:0] OP_JUMP = 4'hE;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      ESPERAR  = 2'd1,
      DETENIDO = 2'd2
   } estado_t;

endpackage

// File: rtl/pila_retorno.sv
// Return-address LIFO for CALL/RET. The caller checks llena/vacia before
// pushing or popping; clear empties the stack and has priority.
module pila_retorno
   import pc_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int PILA_PROF = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              clear,
   input  logic [ADDR_W-1:0] dato_entrada,
   output logic              llena,
   output logic              vacia,
   output logic [ADDR_W-1:0] tope
);

   localparam int CNT_W = $clog2(PILA_PROF + 1);
   localparam int IDX_W = (PILA_PROF > 1) ? $clog2(PILA_PROF) : 1;

   logic [CNT_W-1:0]  cuenta;
   logic [ADDR_W-1:0] memoria [2**IDX_W];
   logic [IDX_W-1:0]  idx_escritura;
   logic [IDX_W-1:0]  idx_tope;

   assign idx_escritura = cuenta[IDX_W-1:0];
   assign idx_tope      = idx_escritura - IDX_W'(1);
   assign llena         = (cuenta == CNT_W'(PILA_PROF));
   assign vacia         = (cuenta == '0);
   assign tope          = memoria[idx_tope];

   // Occupancy counter; a full stack never grows and an empty one never shrinks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cuenta <= '0;
      end else if (clear) begin
         cuenta <= '0;
      end else if (push && !llena) begin
         cuenta <= cuenta + CNT_W'(1);
      end else if (pop && !vacia) begin
         cuenta <= cuenta - CNT_W'(1);
      end
   end

   // Entry storage; contents above the counter are don't-care so no reset is needed.
   always_ff @(posedge clk) begin
      if (push && !llena && !clear) begin
         memoria[idx_escritura] <= dato_entrada;
      end
   end

endmodule

// File: rtl/program_counter_saltos.sv
// Program counter with fetch handshake: issues one-cycle read pulses,
// decodes the fetched opcode and picks the next address (increment, jump,
// call/return through pila_retorno, or halt).
module program_counter_saltos
   import pc_pkg::*;
#(
   parameter int          ADDR_W     = 14,
   parameter int          PILA_PROF  = 4,
   parameter int unsigned DIR_INICIO = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               reiniciar,
   input  logic               lectura_completada,
   input  logic [INSTR_W-1:0] instruccion_actual,
   output logic               leer_siguiente_inst,
   output logic [ADDR_W-1:0]  direccion_siguiente_inst,
   output logic               ejecutando,
   output logic               detenido,
   output logic               error_pila
);

   localparam logic [ADDR_W-1:0] DIR_INI = ADDR_W'(DIR_INICIO);

   estado_t           estado, estado_sig;
   logic [ADDR_W-1:0] dir, dir_sig, dir_inc, destino, tope;
   logic              leer, leer_sig, err, err_sig;
   logic              ejec, ejec_sig, det, det_sig;
   logic              push, pop, clear, llena, vacia;
   logic [3:0]        opcode;
   logic              decodificar, es_halt, fallo_pila;

   assign opcode      = instruccion_actual[OPC_MSB:OPC_LSB];
   assign destino     = instruccion_actual[ADDR_W-1:0];
   assign dir_inc     = dir + ADDR_W'(1);
   assign decodificar = (estado == ESPERAR) && lectura_completada && !leer;
   assign es_halt     = decodificar && (opcode == OP_HALT);
   assign fallo_pila  = decodificar && (((opcode == OP_CALL) && llena) ||
                                        ((opcode == OP_RET)  && vacia));

   generate
      if (ADDR_W < OPC_LSB) begin : g_bits_libres
         logic unused_bits;
         assign unused_bits = ^instruccion_actual[OPC_LSB-1:ADDR_W];
      end
   endgenerate

   pila_retorno #(
      .ADDR_W    (ADDR_W),
      .PILA_PROF (PILA_PROF)
   ) u_pila (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .clear        (clear),
      .dato_entrada (dir_inc),
      .llena        (llena),
      .vacia        (vacia),
      .tope         (tope)
   );

   // State and every output are held in flops so nothing combinational reaches the ports.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado <= REPOSO;
         dir    <= DIR_INI;
         leer   <= 1'b0;
         err    <= 1'b0;
         ejec   <= 1'b0;
         det    <= 1'b0;
      end else begin
         estado <= estado_sig;
         dir    <= dir_sig;
         leer   <= leer_sig;
         err    <= err_sig;
         ejec   <= ejec_sig;
         det    <= det_sig;
      end
   end

   // Next state: restart beats everything, halt or a stack fault parks in DETENIDO.
   always_comb begin
      estado_sig = estado;
      if (reiniciar) begin
         estado_sig = REPOSO;
      end else begin
         unique case (estado)
            REPOSO:   if (iniciar) estado_sig = ESPERAR;
            ESPERAR:  if (es_halt || fallo_pila) estado_sig = DETENIDO;
            DETENIDO: estado_sig = DETENIDO;
            default:  estado_sig = REPOSO;
         endcase
      end
   end

   // Datapath and output values for the coming cycle, including stack control.
   always_comb begin
      dir_sig  = dir;
      leer_sig = 1'b0;
      err_sig  = err;
      push     = 1'b0;
      pop      = 1'b0;
      clear    = 1'b0;
      if (reiniciar) begin
         clear   = 1'b1;
         dir_sig = DIR_INI;
         err_sig = 1'b0;
      end else if ((estado == REPOSO) && iniciar) begin
         dir_sig  = DIR_INI;
         leer_sig = 1'b1;
      end else if (fallo_pila) begin
         err_sig = 1'b1;
      end else if (decodificar && !es_halt) begin
         leer_sig = 1'b1;
         case (opcode)
            OP_JUMP: dir_sig = destino;
            OP_CALL: begin
               push    = 1'b1;
               dir_sig = destino;
            end
            OP_RET: begin
               pop     = 1'b1;
               dir_sig = tope;
            end
            default: dir_sig = dir_inc;
         endcase
      end
      ejec_sig = (estado_sig == ESPERAR);
      det_sig  = (estado_sig == DETENIDO);
   end

   assign leer_siguiente_inst      = leer;
   assign direccion_siguiente_inst = dir;
   assign ejecutando               = ejec;
   assign detenido                 = det;
   assign error_pila               = err;

endmodule

// File: tb/tb_program_counter_saltos.sv
// Directed bench for program_counter_saltos: a table of completed
// instructions with expected fetch results, plus hand sequences for
// restart, halt, stack faults and asynchronous reset.
module tb_program_counter_saltos;

   localparam int ADDR_W = 14;

   typedef struct {
      logic [31:0]       instr;
      logic              leer;
      logic [ADDR_W-1:0] dir;
      logic              ejec;
      logic              det;
      logic              err;
   } vec_t;

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] RET  = 32'hC000_0000;
   localparam logic [31:0] HALT = 32'hF000_0000;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              iniciar = 1'b0;
   logic              reiniciar = 1'b0;
   logic              lectura_completada = 1'b0;
   logic [31:0]       instruccion_actual = '0;
   logic              leer_siguiente_inst;
   logic [ADDR_W-1:0] direccion_siguiente_inst;
   logic              ejecutando;
   logic              detenido;
   logic              error_pila;

   int   check_count = 0;
   int   pass_count  = 0;
   vec_t vectors[15];

   program_counter_saltos #(
      .ADDR_W     (ADDR_W),
      .PILA_PROF  (4),
      .DIR_INICIO (0)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .iniciar                  (iniciar),
      .reiniciar                (reiniciar),
      .lectura_completada       (lectura_completada),
      .instruccion_actual       (instruccion_actual),
      .leer_siguiente_inst      (leer_siguiente_inst),
      .direccion_siguiente_inst (direccion_siguiente_inst),
      .ejecutando               (ejecutando),
      .detenido                 (detenido),
      .error_pila               (error_pila)
   );

   // 10-time-unit clock, rising edges at 5, 15, ...
   always #5 clk = ~clk;

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic checkOutput(input string tag, input logic e_leer, input logic [ADDR_W-1:0] e_dir,
                              input logic e_ejec, input logic e_det, input logic e_err);
      checkValue({tag, ".leer"}, 32'(leer_siguiente_inst), 32'(e_leer));
      checkValue({tag, ".dir"},  32'(direccion_siguiente_inst), 32'(e_dir));
      checkValue({tag, ".ejec"}, 32'(ejecutando), 32'(e_ejec));
      checkValue({tag, ".det"},  32'(detenido), 32'(e_det));
      checkValue({tag, ".err"},  32'(error_pila), 32'(e_err));
   endtask

   // One completed fetch: wait out the request pulse, present the instruction for one edge.
   task automatic applyStimulus(input logic [31:0] instr);
      @(negedge clk);
      checkValue("pulso_un_ciclo", 32'(leer_siguiente_inst), 32'd0);
      lectura_completada = 1'b1;
      instruccion_actual = instr;
      @(negedge clk);
      lectura_completada = 1'b0;
   endtask

   task automatic pulseIniciar();
      @(negedge clk);
      iniciar = 1'b1;
      @(negedge clk);
      iniciar = 1'b0;
   endtask

   task automatic pulseReiniciar();
      @(negedge clk);
      reiniciar = 1'b1;
      @(negedge clk);
      reiniciar = 1'b0;
   endtask

   initial begin
      vectors[0]  = '{NOP,           1'b1, 14'h0001, 1'b1, 1'b0, 1'b0};
      vectors[1]  = '{NOP,           1'b1, 14'h0002, 1'b1, 1'b0, 1'b0};
      vectors[2]  = '{NOP,           1'b1, 14'h0003, 1'b1, 1'b0, 1'b0};
      vectors[3]  = '{NOP,           1'b1, 14'h0004, 1'b1, 1'b0, 1'b0};
      vectors[4]  = '{NOP,           1'b1, 14'h0005, 1'b1, 1'b0, 1'b0};
      vectors[5]  = '{32'hE000_0100, 1'b1, 14'h0100, 1'b1, 1'b0, 1'b0};
      vectors[6]  = '{32'hD000_0200, 1'b1, 14'h0200, 1'b1, 1'b0, 1'b0};
      vectors[7]  = '{RET,           1'b1, 14'h0101, 1'b1, 1'b0, 1'b0};
      vectors[8]  = '{32'hE000_3FFF, 1'b1, 14'h3FFF, 1'b1, 1'b0, 1'b0};
      vectors[9]  = '{NOP,           1'b1, 14'h0000, 1'b1, 1'b0, 1'b0};
      vectors[10] = '{32'hD000_0010, 1'b1, 14'h0010, 1'b1, 1'b0, 1'b0};
      vectors[11] = '{32'hD000_0020, 1'b1, 14'h0020, 1'b1, 1'b0, 1'b0};
      vectors[12] = '{32'hD000_0030, 1'b1, 14'h0030, 1'b1, 1'b0, 1'b0};
      vectors[13] = '{32'hD000_0040, 1'b1, 14'h0040, 1'b1, 1'b0, 1'b0};
      vectors[14] = '{32'hD000_0050, 1'b0, 14'h0040, 1'b0, 1'b1, 1'b1};

      // Reset values
      repeat (2) @(negedge clk);
      checkOutput("reset", 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      // Start, then the table of completions
      pulseIniciar();
      checkOutput("iniciar", 1'b1, 14'h0000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vectors[i].instr);
         checkOutput($sformatf("vec%0d", i), vectors[i].leer, vectors[i].dir,
                     vectors[i].ejec, vectors[i].det, vectors[i].err);
      end

      // RET on an empty stack after restart
      pulseReiniciar();
      checkOutput("reiniciar_err", 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
      pulseIniciar();
      checkOutput("iniciar2", 1'b1, 14'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(RET);
      checkOutput("ret_vacia", 1'b0, 14'h0000, 1'b0, 1'b1, 1'b1);

      // HALT at address 3, iniciar ignored, restart
      pulseReiniciar();
      pulseIniciar();
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(NOP);
         checkOutput($sformatf("pre_halt%0d", i), 1'b1, ADDR_W'(i), 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(HALT);
      checkOutput("halt", 1'b0, 14'h0003, 1'b0, 1'b1, 1'b0);
      pulseIniciar();
      checkOutput("iniciar_detenido", 1'b0, 14'h0003, 1'b0, 1'b1, 1'b0);
      pulseReiniciar();
      checkOutput("reiniciar_halt", 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);

      // Restart coincident with a completion, then a stray completion in REPOSO
      pulseIniciar();
      applyStimulus(NOP);
      checkOutput("pre_coinc", 1'b1, 14'h0001, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reiniciar = 1'b1;
      lectura_completada = 1'b1;
      instruccion_actual = NOP;
      @(negedge clk);
      reiniciar = 1'b0;
      lectura_completada = 1'b0;
      checkOutput("reiniciar_coinc", 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(NOP);
      checkOutput("lectura_reposo", 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);

      // Completion coincident with the request pulse is ignored
      @(negedge clk);
      iniciar = 1'b1;
      @(negedge clk);
      iniciar = 1'b0;
      lectura_completada = 1'b1;
      instruccion_actual = 32'hE000_0100;
      @(negedge clk);
      lectura_completada = 1'b0;
      checkOutput("lectura_con_pulso", 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(NOP);
      checkOutput("post_pulso", 1'b1, 14'h0001, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset between request and completion; late completion ignored
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("reset_async", 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      lectura_completada = 1'b1;
      instruccion_actual = NOP;
      @(negedge clk);
      lectura_completada = 1'b0;
      checkOutput("lectura_tardia", 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
